// File: rtl/tile_map_writer.sv
// Tile map writer: queues CPU tile WRITE / map CLEAR commands and commits them to tile memory only inside the vblank write window.
// Latency: a queued WRITE reaches mem_we 2 clk after the pop (pop needs window_open); CLEAR streams one word per open-window cycle.
// Backpressure: cmd_ready drops while the FIFO is full; CLEAR pauses with the window closed and resumes where it stopped.
// Optional: define TILE_BOUNDS_CHECK_EN to drop out-of-range WRITEs and raise the sticky err flag.
module tile_map_writer #(
    parameter int SYS_DATA_WIDTH = 16,
    parameter int SYS_ADDR_WIDTH = 16,
    parameter int TILES_X        = 40,
    parameter int TILES_Y        = 30,
    parameter logic [SYS_ADDR_WIDTH-1:0] BASE_ADDR = 16'hC000,
    parameter int FIFO_DEPTH     = 8,
    parameter int WINDOW_CYCLES  = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vga_vs,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_op,
    input  logic [5:0]                cmd_x,
    input  logic [4:0]                cmd_y,
    input  logic [SYS_DATA_WIDTH-1:0] cmd_data,
    output logic                      mem_we,
    output logic [SYS_ADDR_WIDTH-1:0] mem_addr,
    output logic [SYS_DATA_WIDTH-1:0] mem_wdata,
    output logic                      window_open,
    output logic                      busy,
    output logic                      err
);

    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = PTR_W + 1;
    localparam int TILE_COUNT = TILES_X * TILES_Y;
    localparam int IDX_W      = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;
    localparam int WIN_W      = $clog2(WINDOW_CYCLES + 1);

    typedef struct packed {
        logic                      op;
        logic [5:0]                x;
        logic [4:0]                y;
        logic [SYS_DATA_WIDTH-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLEAR
    } state_t;

    // ---------------- command FIFO ----------------
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             push;
    logic             pop;
    cmd_t             head;

    assign push = cmd_valid & cmd_ready;
    assign head = fifo_mem[rd_ptr];

    // Occupancy after this cycle's push/pop; feeds the registered ready/busy flags.
    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    // Storage is not reset: emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: cmd_op, x: cmd_x, y: cmd_y, data: cmd_data};
        end
    end

    // Pointer and occupancy bookkeeping; cmd_ready is registered from next-state fullness.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_n;
            cmd_ready <= (count_n != CNT_W'(FIFO_DEPTH));
        end
    end

    // ---------------- vblank write window ----------------
    logic             vs_prev;
    logic             vs_fall;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_cnt_n;

    assign vs_fall = vs_prev & ~vga_vs;

    // A falling vsync edge (re)arms the window; otherwise it counts down to zero.
    always_comb begin
        win_cnt_n = win_cnt;
        if (vs_fall) begin
            win_cnt_n = WIN_W'(WINDOW_CYCLES);
        end else if (win_cnt != '0) begin
            win_cnt_n = win_cnt - WIN_W'(1);
        end
    end

    // Window counter, edge-detect history and the registered window flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vs_prev     <= 1'b1;
            win_cnt     <= '0;
            window_open <= 1'b0;
        end else begin
            vs_prev     <= vga_vs;
            win_cnt     <= win_cnt_n;
            window_open <= (win_cnt_n != '0);
        end
    end

    // ---------------- commit FSM ----------------
    state_t                    state;
    state_t                    state_n;
    cmd_t                      cur;
    cmd_t                      cur_n;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_n;
    logic                      we_n;
    logic [SYS_ADDR_WIDTH-1:0] addr_n;
    logic [SYS_DATA_WIDTH-1:0] wdata_n;
    logic                      err_n;
    logic [SYS_ADDR_WIDTH-1:0] tile_addr;

    // Row-major tile address; wraps modulo the address width by construction.
    assign tile_addr = BASE_ADDR
                     + SYS_ADDR_WIDTH'(cur.y) * SYS_ADDR_WIDTH'(TILES_X)
                     + SYS_ADDR_WIDTH'(cur.x);

`ifdef TILE_BOUNDS_CHECK_EN
    logic in_range;
    assign in_range = (32'(cur.x) < TILES_X) && (32'(cur.y) < TILES_Y);
`endif

    // Next-state and memory-port decisions. A CLEAR writes its first word on the
    // pop cycle so the map fill uses every open-window cycle.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        idx_n   = idx;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        err_n   = err;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (window_open && (count != '0)) begin
                    pop   = 1'b1;
                    cur_n = head;
                    if (head.op) begin
                        we_n    = 1'b1;
                        addr_n  = BASE_ADDR;
                        wdata_n = head.data;
                        idx_n   = IDX_W'(1);
                        state_n = (TILE_COUNT > 1) ? ST_CLEAR : ST_IDLE;
                    end else begin
                        state_n = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Completes regardless of the window so a late pop is never lost.
                state_n = ST_IDLE;
`ifdef TILE_BOUNDS_CHECK_EN
                if (in_range) begin
                    we_n    = 1'b1;
                    addr_n  = tile_addr;
                    wdata_n = cur.data;
                end else begin
                    err_n = 1'b1;
                end
`else
                we_n    = 1'b1;
                addr_n  = tile_addr;
                wdata_n = cur.data;
`endif
            end
            ST_CLEAR: begin
                if (window_open) begin
                    we_n    = 1'b1;
                    addr_n  = BASE_ADDR + SYS_ADDR_WIDTH'(idx);
                    wdata_n = cur.data;
                    if (idx == IDX_W'(TILE_COUNT - 1)) begin
                        idx_n   = '0;
                        state_n = ST_IDLE;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM state plus registered memory port and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cur       <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            idx       <= idx_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            err       <= err_n;
            busy      <= (state_n != ST_IDLE) || (count_n != '0);
        end
    end

endmodule

// File: tb/tb_tile_map_writer.sv
// Bench for tile_map_writer: directed command sequences, expected writes queued
// as they are issued and compared by an independent write monitor.
module tb_tile_map_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_vs;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [5:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [15:0] cmd_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        window_open;
    logic        busy;
    logic        err;

`ifdef TILE_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    tile_map_writer #(.WINDOW_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .vga_vs(vga_vs),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .window_open(window_open), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          wr_seen = 0;
    int          cyc = 0;
    int          last_cyc = -1;
    bit          gap_chk = 1'b0;
    logic [31:0] sb [$];
    logic [31:0] mon_exp;
    logic [15:0] t2_addr [9];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
            end else begin
                mon_exp = sb.pop_front();
                check("write", {mem_addr, mem_wdata}, mon_exp);
            end
            if (gap_chk) begin
                if (last_cyc >= 0) check("t2_gap", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic op, input logic [5:0] x, input logic [4:0] y, input logic [15:0] d);
        int budget;
        budget = 50;
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && budget > 0) begin
            tick(1);
            budget--;
        end
        if (cmd_ready) begin
            tick(1);
        end else begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got cmd_ready=0 expected 1 within 50 cycles");
        end
        cmd_valid = 1'b0;
    endtask

    // One-cycle low pulse on vga_vs; returns one cycle after the edge is seen.
    task automatic vs_fall();
        vga_vs = 1'b0;
        tick(1);
        vga_vs = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        t2_addr = '{16'hC000, 16'hC029, 16'hC052, 16'hC07B, 16'hC0A4,
                    16'hC0CD, 16'hC0F6, 16'hC11F, 16'hC148};
        reset = 1'b0; vga_vs = 1'b1; cmd_valid = 1'b0;
        cmd_op = 1'b0; cmd_x = '0; cmd_y = '0; cmd_data = '0;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("rst_ready",  32'(cmd_ready),   32'd1);
        check("rst_we",     32'(mem_we),      32'd0);
        check("rst_addr",   32'(mem_addr),    32'd0);
        check("rst_wdata",  32'(mem_wdata),   32'd0);
        check("rst_window", 32'(window_open), 32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_err",    32'(err),         32'd0);

        // 1: single WRITE held until vblank, then committed 3 cycles after the edge
        sb.push_back({16'hC055, 16'h00AB});
        push(1'b0, 6'd5, 5'd2, 16'h00AB);
        tick(5);
        check("t1_held_writes", 32'(wr_seen), 32'd0);
        check("t1_busy",        32'(busy),    32'd1);
        vs_fall();
        check("t1_window", 32'(window_open), 32'd1);
        tick(2);
        check("t1_we",   32'(mem_we),   32'd1);
        check("t1_addr", 32'(mem_addr), 32'hC055);
        tick(110);
        check("t1_closed", 32'(window_open), 32'd0);
        check("t1_idle",   32'(busy),        32'd0);

        // 2: fill the FIFO, hold the 9th, drain in order at one write per 2 cycles
        w0 = wr_seen;
        for (int i = 0; i < 9; i++) sb.push_back({t2_addr[i], 16'h1100 + 16'(i)});
        for (int i = 0; i < 8; i++) push(1'b0, 6'(i), 5'(i), 16'h1100 + 16'(i));
        check("t2_full_ready", 32'(cmd_ready), 32'd0);
        cmd_op = 1'b0; cmd_x = 6'd8; cmd_y = 5'd8; cmd_data = 16'h1108; cmd_valid = 1'b1;
        tick(3);
        check("t2_still_full", 32'(cmd_ready), 32'd0);
        check("t2_no_write",   32'(wr_seen - w0), 32'd0);
        gap_chk = 1'b1; last_cyc = -1;
        vs_fall();
        push(1'b0, 6'd8, 5'd8, 16'h1108);
        tick(40);
        gap_chk = 1'b0;
        check("t2_count", 32'(wr_seen - w0), 32'd9);
        tick(80);

        // 3: CLEAR spanning 12 windows of 100 writes each
        w0 = wr_seen;
        for (int i = 0; i < 1200; i++) sb.push_back({16'hC000 + 16'(i), 16'h0000});
        push(1'b1, 6'd0, 5'd0, 16'h0000);
        vs_fall();
        tick(150);
        check("t3_win1_count", 32'(wr_seen - w0), 32'd100);
        check("t3_win1_last",  32'(mem_addr), 32'hC063);
        check("t3_paused_we",  32'(mem_we),   32'd0);
        check("t3_busy_mid",   32'(busy),     32'd1);
        vs_fall();
        tick(150);
        check("t3_win2_count", 32'(wr_seen - w0), 32'd200);
        check("t3_win2_last",  32'(mem_addr), 32'hC0C7);
        for (int f = 0; f < 10; f++) begin
            vs_fall();
            tick(150);
        end
        check("t3_total", 32'(wr_seen - w0), 32'd1200);
        check("t3_last",  32'(mem_addr), 32'hC4AF);
        check("t3_idle",  32'(busy), 32'd0);

        // 4: reset in the middle of a CLEAR drops it and the queued WRITE
        w0 = wr_seen;
        for (int i = 0; i < 9; i++) sb.push_back({16'hC000 + 16'(i), 16'h1234});
        push(1'b1, 6'd0, 5'd0, 16'h1234);
        push(1'b0, 6'd1, 5'd1, 16'h5555);
        vs_fall();
        tick(9);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("t4_we",     32'(mem_we),      32'd0);
        check("t4_busy",   32'(busy),        32'd0);
        check("t4_ready",  32'(cmd_ready),   32'd1);
        check("t4_window", 32'(window_open), 32'd0);
        check("t4_before", 32'(wr_seen - w0), 32'd9);
        vs_fall();
        tick(110);
        check("t4_after",  32'(wr_seen - w0), 32'd9);

        // 5: out-of-range WRITE (dropped with bounds check, wrapped without)
        w0 = wr_seen;
        if (!BCHK) sb.push_back({16'hC028, 16'hBEEF});
        sb.push_back({16'hC000, 16'h0C0C});
        push(1'b0, 6'd40, 5'd0, 16'hBEEF);
        push(1'b0, 6'd0,  5'd0, 16'h0C0C);
        vs_fall();
        tick(10);
        check("t5_err",    32'(err), 32'(BCHK));
        check("t5_writes", 32'(wr_seen - w0), BCHK ? 32'd1 : 32'd2);
        tick(100);
        check("t5_err_sticky", 32'(err), 32'(BCHK));

        // 6: a second falling edge mid-window restarts the 100-cycle window
        vs_fall();
        tick(49);
        vs_fall();
        tick(99);
        check("t6_hold",  32'(window_open), 32'd1);
        tick(1);
        check("t6_close", 32'(window_open), 32'd0);

        tick(5);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
